io_port: RTL and testbench
==========================

# io_port

Peripheral-side I/O block for the 16-bit single-cycle CPU: the receiving end of the controller's `outwe` and `portSel` strobes. It queues OUT-instruction data (op 6) in a small FIFO and drains it to an external valid/ready sink. It captures external input into a one-entry holding register that an IN instruction (op 7) consumes through the write-back path. It raises `port_stall` whenever the current instruction's port access cannot complete this cycle.

## Interface
- `WIDTH`, 16: data width; equals the register-file word.
- `DEPTH`, 4: OUT FIFO entries; must be a power of two and ≥ 2.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `outwe`  in  1  OUT write strobe from the controller; one cycle per op 6.
- `out_data`  in  WIDTH  register-file read data to be output.
- `portSel`  in  1  IN read strobe from the controller; one cycle per op 7.
- `in_data`  out  WIDTH  holding-register contents, muxed into write-back.
- `port_stall`  out  1  the port access in this cycle was not performed.
- `tx_data`  out  WIDTH  FIFO head.
- `tx_valid`  out  1  FIFO not empty.
- `tx_ready`  in  1  external sink accepts `tx_data`.
- `rx_data`  in  WIDTH  external input word.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  holding register is empty.
- `err`  out  2  sticky flags: bit 0 = OUT dropped while FIFO full; bit 1 = IN while holding register empty.

## Operation
- **Push:** `outwe & !full` writes `out_data` at the write pointer, then increments `wptr` and `count`.
- **Full push:** `outwe & full` drops the word, asserts `port_stall`, and sets `err[0]`. A pop in the same cycle does not make room.
- **Pop:** `tx_valid & tx_ready` increments `rptr` and decrements `count`.
- **Push and pop together (not full):** `count` is unchanged and both pointers advance.
- **Pointer wrap:** pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits, range 0..DEPTH.
- **FIFO flags:** `full = (count == DEPTH)`; `tx_valid = (count != 0)`; `tx_data = mem[rptr]`.
- **Holding register:** `hold_full` is cleared when `portSel & hold_full`, which hands `in_data` to write-back this cycle.
- **IN with empty holding register:** `portSel & !hold_full` asserts `port_stall` and sets `err[1]`. `in_data` keeps its last value.
- **Input capture:** `rx_ready = !hold_full`. When `rx_valid & rx_ready`, `rx_data` is loaded into the holding register and `hold_full` is set.
- A word cannot be captured and consumed in the same cycle, because `rx_ready` is low while `hold_full` is set.
- **Stall equation:** `port_stall = (outwe & full) | (portSel & !hold_full)`. This is the only combinational output from the CPU strobes.
- **Error flags:** `err` bits are cleared only by reset.
- **Illegal strobes:** `outwe` and `portSel` are never both high; the controller guarantees this, and the bench asserts it.

## Timing
- **Reset values:** `count`, `wptr`, `rptr`, `hold_full` = 0; holding register = 0; `err` = 0.
- **Outputs during reset:** `tx_valid` = 0, `rx_ready` = 1, `in_data` = 0, `err` = 0. `port_stall` equals `portSel`, and `tx_data` is `mem[0]`, which is not reset.
- **Reset mid-operation:** FIFO contents are discarded and a held input word is lost. `tx_valid` falls asynchronously with `rst`.
- **OUT latency:** `outwe` at edge N gives `tx_valid` = 1 after edge N. Minimum in-to-out latency is 1 cycle.
- **IN latency:** `rx_valid & rx_ready` at edge N makes `in_data` valid and `rx_ready` = 0 after edge N.
- **IN consume:** `portSel` in cycle N+1 or later consumes the word, and `rx_ready` returns high after that edge.
- **Throughput:**
  - The FIFO sustains one push and one pop per cycle.
  - The input side accepts at most one word every 2 cycles.
- **Stall timing:** `port_stall` is valid in the same cycle as the strobe, ahead of the CPU's write-back edge.

## Structure
- Shared package `io_port_pkg`:
  - `IO_WIDTH` = 16 and `IO_DEPTH` = 4;
  - the `err` bit positions `ERR_OUT_DROP` = 0 and `ERR_IN_EMPTY` = 1;
  - the opcode constants `OP_OUT` = 6 and `OP_IN` = 7, shared with the controller.
- One sub-module, `io_tx_fifo`: parameterised synchronous FIFO with push/pop/full/empty/count.
- `io_port` holds the holding register, the stall logic and the error flags.

## Test plan
- **Reset:** assert `rst` mid-stream with 3 words queued and the holding register full. Required: `tx_valid` = 0 and `rx_ready` = 1 immediately; `err` = 0; `count` = 0 after release.
- **FIFO order:** push 0x0001..0x0004 with `tx_ready` = 0. Required: `full`, and a fifth `outwe` (0x0005) gives `port_stall` = 1 and `err` = 2'b01. Then with `tx_ready` = 1, `tx_data` is 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles, then `tx_valid` = 0.
- **Concurrent push/pop:** one push and one pop per cycle for 10 cycles starting with count 2. Required: count stays 2 and 10 words exit in order across two pointer wraps.
- **IN path:** `rx_data` = 0xBEEF with `rx_valid` at edge N. Required: `in_data` = 0xBEEF and `rx_ready` = 0 after N. `portSel` at N+2 gives `port_stall` = 0, and `rx_ready` = 1 after N+2.
- **IN underflow:** `portSel` with the holding register empty. Required: `port_stall` = 1, `err[1]` set, and `in_data` unchanged.
- **Full FIFO, push plus pop same cycle:** with the FIFO full, `outwe` and `tx_ready` in the same cycle. Required: the pop occurs, the push is dropped, `port_stall` = 1, and `count` = DEPTH−1.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared constants for the CPU I/O port: widths, error flag positions and
// the opcodes the controller decodes into outwe / portSel.
package io_port_pkg;

  localparam int IO_WIDTH = 16;
  localparam int IO_DEPTH = 4;

  // Bit positions inside the sticky err vector
  localparam int ERR_OUT_DROP = 0;
  localparam int ERR_IN_EMPTY = 1;

  // Opcodes shared with the controller
  localparam logic [3:0] OP_OUT = 4'd6;
  localparam logic [3:0] OP_IN  = 4'd7;

endpackage

// File: rtl/io_tx_fifo.sv
// Synchronous FIFO for OUT-instruction data. A push while full and a pop
// while empty are ignored, so a full FIFO never accepts a word even when a
// pop happens in the same cycle. Storage is not reset; only the pointers
// and the occupancy count are.
module io_tx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rptr];

  // Storage write at the write pointer
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_port.sv
// Peripheral-side I/O block for the CPU. OUT data is queued in io_tx_fifo
// and drained to an external sink; external input is captured in a
// one-entry holding register consumed by IN. port_stall flags a strobe
// whose access could not be performed this cycle.
//
// Handshakes: a word moves on tx (tx_valid & tx_ready) or rx
// (rx_valid & rx_ready) exactly on a rising clk edge where both are high;
// valid never depends on ready, and the producer holds data stable while
// valid is high and ready is low.
module io_port
  import io_port_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             outwe,
  input  logic [WIDTH-1:0] out_data,
  input  logic             portSel,
  output logic [WIDTH-1:0] in_data,
  output logic             port_stall,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [1:0]       err
);

  logic             fifo_full;
  logic             fifo_empty;
  logic             hold_full;
  logic [WIDTH-1:0] hold_reg;
  logic             out_drop;
  logic             in_empty;

  io_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (outwe),
    .push_data (out_data),
    .pop       (tx_ready),
    .pop_data  (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign tx_valid   = ~fifo_empty;
  assign rx_ready   = ~hold_full;
  assign in_data    = hold_reg;
  assign out_drop   = outwe & fifo_full;
  assign in_empty   = portSel & ~hold_full;
  assign port_stall = out_drop | in_empty;

  // Holding register: consumed by IN when full, loaded from rx when empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_reg  <= '0;
    end else if (portSel && hold_full) begin
      hold_full <= 1'b0;
    end else if (rx_valid && !hold_full) begin
      hold_reg  <= rx_data;
      hold_full <= 1'b1;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= '0;
    end else begin
      if (out_drop) begin
        err[ERR_OUT_DROP] <= 1'b1;
      end
      if (in_empty) begin
        err[ERR_IN_EMPTY] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_port.sv
// Bench for io_port: directed sequences plus a random OUT/drain phase.
// Words accepted on the OUT side and on rx are queued as expectations and
// compared when they leave on tx or are consumed by IN.
module tb_io_port;
  import io_port_pkg::*;

  localparam int W = IO_WIDTH;
  localparam int D = IO_DEPTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         outwe;
  logic [W-1:0] out_data;
  logic         portSel;
  logic [W-1:0] in_data;
  logic         port_stall;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [1:0]   err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] in_q[$];
  logic [W-1:0] last_in;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  io_port dut (
    .clk        (clk),
    .rst        (rst),
    .outwe      (outwe),
    .out_data   (out_data),
    .portSel    (portSel),
    .in_data    (in_data),
    .port_stall (port_stall),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .err        (err)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Strobes from the controller are mutually exclusive
  always @(negedge clk) begin
    assert (!(outwe && portSel)) else $error("outwe and portSel both high");
  end

  // tx scoreboard: a transfer happens at the next rising edge
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check("tx_unexpected", W'(1), W'(0));
      end else begin
        check("tx_data", tx_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic out_word(input logic [W-1:0] d, input logic exp_stall);
    outwe    = 1'b1;
    out_data = d;
    @(negedge clk);
    check("out_stall", W'(port_stall), W'(exp_stall));
    if (!exp_stall) exp_q.push_back(d);
    step();
    outwe = 1'b0;
  endtask

  task automatic rx_word(input logic [W-1:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    @(negedge clk);
    check("rx_ready_before", W'(rx_ready), W'(1));
    in_q.push_back(d);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic in_read(input logic exp_stall);
    portSel = 1'b1;
    @(negedge clk);
    check("in_stall", W'(port_stall), W'(exp_stall));
    if (!exp_stall) begin
      if (in_q.size() == 0) begin
        check("in_unexpected", W'(1), W'(0));
      end else begin
        last_in = in_q.pop_front();
        check("in_data", in_data, last_in);
      end
    end else begin
      check("in_data_kept", in_data, last_in);
    end
    step();
    portSel = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mcount;
    logic o, r, ps, pp, st;
    logic [W-1:0] d;

    rst = 1'b1; outwe = 1'b0; out_data = '0; portSel = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0; last_in = '0;

    // Outputs during reset
    #1 portSel = 1'b1;
    #1 check("rst_stall_sel", W'(port_stall), W'(1));
    portSel = 1'b0;
    #1 check("rst_stall_idle", W'(port_stall), W'(0));
    check("rst_tx_valid", W'(tx_valid), W'(0));
    check("rst_rx_ready", W'(rx_ready), W'(1));
    check("rst_in_data", in_data, W'(0));
    check("rst_err", W'(err), W'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();

    // FIFO order and full drop
    for (int i = 1; i <= 4; i++) out_word(W'(i), 1'b0);
    check("full_flag", W'(dut.u_fifo.full), W'(1));
    check("full_count", W'(dut.u_fifo.count), W'(4));
    out_word(W'(5), 1'b1);
    check("err_drop", W'(err), W'(2'b01));
    tx_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check("drain_tx_valid", W'(tx_valid), W'(0));
    check("drain_q_empty", W'(exp_q.size()), W'(0));
    step();

    // Concurrent push/pop at count 2 across pointer wraps
    tx_ready = 1'b0;
    out_word(16'h00A0, 1'b0);
    out_word(16'h00A1, 1'b0);
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("cc_count", W'(dut.u_fifo.count), W'(2));
      out_word(W'(16'h0010 + i), 1'b0);
    end
    check("cc_count_end", W'(dut.u_fifo.count), W'(2));
    repeat (2) step();
    @(negedge clk);
    check("cc_tx_valid", W'(tx_valid), W'(0));
    check("cc_q_empty", W'(exp_q.size()), W'(0));
    step();
    tx_ready = 1'b0;

    // IN path
    rx_word(16'hBEEF);
    check("in_after_capture", in_data, 16'hBEEF);
    check("rx_ready_full", W'(rx_ready), W'(0));
    step();
    in_read(1'b0);
    check("rx_ready_consumed", W'(rx_ready), W'(1));

    // IN underflow
    in_read(1'b1);
    check("err_in_empty", W'(err), W'(2'b11));
    check("in_underflow_data", in_data, 16'hBEEF);
    check("rx_ready_underflow", W'(rx_ready), W'(1));

    // Full FIFO with push and pop in the same cycle
    for (int i = 1; i <= 4; i++) out_word(W'(16'h0020 + i), 1'b0);
    outwe = 1'b1; out_data = 16'h0025; tx_ready = 1'b1;
    @(negedge clk);
    check("full_pp_stall", W'(port_stall), W'(1));
    step();
    outwe = 1'b0; tx_ready = 1'b0;
    check("full_pp_count", W'(dut.u_fifo.count), W'(D - 1));
    check("full_pp_head", tx_data, 16'h0022);

    // Reset mid-stream with 3 words queued and the holding register full
    rx_word(16'h1234);
    check("pre_rst_rx_ready", W'(rx_ready), W'(0));
    #2 rst = 1'b1;
    #1 check("mid_rst_tx_valid", W'(tx_valid), W'(0));
    check("mid_rst_rx_ready", W'(rx_ready), W'(1));
    check("mid_rst_err", W'(err), W'(0));
    check("mid_rst_in_data", in_data, W'(0));
    exp_q.delete();
    in_q.delete();
    last_in = '0;
    @(negedge clk) rst = 1'b0;
    step();
    check("post_rst_count", W'(dut.u_fifo.count), W'(0));
    check("post_rst_tx_valid", W'(tx_valid), W'(0));

    // Random OUT traffic against a small occupancy model
    mcount = 0;
    for (int i = 0; i < 40; i++) begin
      o = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) == 0);
      d = W'($urandom_range(0, 16'hFFFF));
      st = o && (mcount == D);
      ps = o && (mcount != D);
      pp = r && (mcount != 0);
      tx_ready = r;
      if (o) out_word(d, st);
      else step();
      mcount = mcount + int'(ps) - int'(pp);
      check("rnd_count", W'(dut.u_fifo.count), W'(mcount));
    end
    tx_ready = 1'b1;
    repeat (D + 1) step();
    @(negedge clk);
    check("rnd_tx_valid", W'(tx_valid), W'(0));
    check("rnd_q_empty", W'(exp_q.size()), W'(0));
    tx_ready = 1'b0;

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
